// File: rtl/fifo_load_ctrl.sv
// fifo_load_ctrl
// Sequences the five-operand FIFO bank (R2, N, M, phi_N, Ei) of the Montgomery
// RSA datapath. A single 32-bit host stream is written into the bank one
// operand after another. The controller then serves word-read requests from
// the exponentiation engine. Per-FIFO occupancy counters keep reads within
// what was written and detect the end of the serve phase.
//
// Ports:
//   clka, rstn            clock; synchronous active-low reset
//   start                 one-cycle pulse, begins a load sequence from IDLE
//   host_valid/host_data  host word stream
//   host_ready            high while loading (combinational)
//   din, wr_en[4:0]       registered write data / one-hot write enables
//   rd_req, rd_sel[2:0]   engine read request and FIFO index
//   rd_en[4:0]            registered one-hot read enables
//   rd_valid              requested word is on the bank dout
//   load_done, all_done   one-cycle completion pulses
//   err                   sticky illegal-request flag, cleared by reset/start
module fifo_load_ctrl #(
    parameter int NWORDS = 32,
    parameter int CNT_W  = 8
) (
    input  logic        clka,
    input  logic        rstn,
    input  logic        start,
    input  logic        host_valid,
    input  logic [31:0] host_data,
    output logic        host_ready,
    output logic [31:0] din,
    output logic [4:0]  wr_en,
    input  logic        rd_req,
    input  logic [2:0]  rd_sel,
    output logic [4:0]  rd_en,
    output logic        rd_valid,
    output logic        load_done,
    output logic        all_done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    state_t           state;
    state_t           state_nx;
    logic [2:0]       op_idx;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] occ [5];

    logic accept;
    logic last_word;
    logic sel_nonzero;
    logic rd_ok;
    logic all_empty;

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a value held and infer a latch.
    always_comb begin
        host_ready  = (state == LOAD);
        accept      = host_ready && host_valid;
        last_word   = (op_idx == 3'd4) && (word_cnt == LAST_WORD);
        sel_nonzero = 1'b0;
        all_empty   = 1'b1;
        // Looping over legal indices avoids indexing the counter array with
        // an out-of-range rd_sel (5..7).
        for (int k = 0; k < 5; k++) begin
            if (occ[k] != '0) all_empty = 1'b0;
            if ((rd_sel == 3'(k)) && (occ[k] != '0)) sel_nonzero = 1'b1;
        end
        rd_ok = (state == SERVE) && rd_req && sel_nonzero;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (accept && last_word) state_nx = SERVE;
            // The last decrement lands on the edge before this test sees all
            // counters at zero, so the exit coincides with the final rd_valid.
            SERVE:   if (all_empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clka) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clka) begin
        if (!rstn) begin
            op_idx    <= '0;
            word_cnt  <= '0;
            din       <= '0;
            wr_en     <= '0;
            rd_en     <= '0;
            rd_valid  <= 1'b0;
            load_done <= 1'b0;
            all_done  <= 1'b0;
            err       <= 1'b0;
            // NOTE: the occupancy counters are reset explicitly; they must
            // agree with the FIFO bank, which is emptied by the same reset.
            for (int k = 0; k < 5; k++) occ[k] <= '0;
        end else begin
            wr_en     <= '0;
            rd_en     <= '0;
            load_done <= 1'b0;
            // The bank registers its read, so data follows rd_en by a cycle.
            rd_valid  <= |rd_en;
            all_done  <= (state == SERVE) && all_empty;

            if ((state == IDLE) && start) begin
                op_idx   <= '0;
                word_cnt <= '0;
                err      <= 1'b0;
            end

            if (accept) begin
                din       <= host_data;
                wr_en     <= 5'b00001 << op_idx;
                load_done <= last_word;
                if (word_cnt == LAST_WORD) begin
                    word_cnt <= '0;
                    op_idx   <= last_word ? 3'd0 : op_idx + 3'd1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end

            if (rd_ok) begin
                rd_en <= 5'b00001 << rd_sel;
            end else if (rd_req) begin
                // Bad index, empty FIFO, or request outside SERVE.
                err <= 1'b1;
            end

            // Increments only occur in LOAD and decrements only in SERVE.
            for (int k = 0; k < 5; k++) begin
                if (accept && (op_idx == 3'(k))) occ[k] <= occ[k] + 1'b1;
                if (rd_ok && (rd_sel == 3'(k)))  occ[k] <= occ[k] - 1'b1;
            end
        end
    end

endmodule
